// File: rtl/gate_bcd_counter.sv
// ----------------------------------------------------------------------------
// gate_bcd_counter: range-selected gate window with a 4-digit BCD edge counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module gate_bcd_counter #(
  parameter int GATE_1S = 100000000,
  parameter int GW      = 27
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        reset,
  input  logic [1:0]  std_f_sel,
  input  logic        fin,
  output logic        cntover,
  output logic        cntlow,
  output logic [15:0] q,
  output logic [1:0]  q_range,
  output logic        valid
);

  localparam logic [GW-1:0] LOAD_1K   = GW'(GATE_1S - 1);
  localparam logic [GW-1:0] LOAD_10K  = GW'(GATE_1S / 10 - 1);
  localparam logic [GW-1:0] LOAD_100K = GW'(GATE_1S / 100 - 1);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gate_cnt_q, gate_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    rng_q, rng_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [15:0]   q_q, q_d;
  logic [1:0]    q_range_q, q_range_d;
  logic          valid_q, valid_d;
  logic          cntover_q, cntover_d;
  logic          cntlow_q, cntlow_d;

  logic          rise;
  logic [15:0]   inc_sum;
  logic          inc_carry;

  // Ripple +1 across the four BCD digits; bit 16 is the carry out of d3.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rng_d      = rng_q;
    q_d        = q_q;
    q_range_d  = q_range_q;
    valid_d    = 1'b0;
    cntover_d  = 1'b0;
    cntlow_d   = 1'b0;

    s1_d = fin;
    s2_d = s1_q;
    s3_d = s2_q;
    rise = s2_q & ~s3_q;

    {inc_carry, inc_sum} = bcd_inc(cnt_q);

    case (state_q)
      ST_ARM: begin
        cnt_d = 16'h0000;
        ovf_d = 1'b0;
        rng_d = std_f_sel;
        case (std_f_sel)
          2'b11:   gate_cnt_d = LOAD_1K;
          2'b00:   gate_cnt_d = LOAD_100K;
          default: gate_cnt_d = LOAD_10K;
        endcase
        state_d = ST_GATE;
      end
      ST_GATE: begin
        if (rise && !ovf_q) begin
          if (inc_carry) begin
            ovf_d = 1'b1;
            cnt_d = 16'h9999;
          end else begin
            cnt_d = inc_sum;
          end
        end
        if (gate_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          gate_cnt_d = gate_cnt_q - GW'(1);
        end
      end
      ST_DONE: begin
        q_d       = cnt_q;
        q_range_d = rng_q;
        valid_d   = 1'b1;
        cntover_d = ovf_q;
        cntlow_d  = ~ovf_q & (cnt_q[15:12] == 4'd0);
        state_d   = ST_ARM;
      end
      default: state_d = ST_ARM;
    endcase

    // Restart aborts whatever is in progress and suppresses its report.
    if (reset) begin
      state_d   = ST_ARM;
      q_d       = q_q;
      q_range_d = q_range_q;
      valid_d   = 1'b0;
      cntover_d = 1'b0;
      cntlow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q    <= ST_ARM;
      gate_cnt_q <= '0;
      cnt_q      <= 16'h0000;
      ovf_q      <= 1'b0;
      rng_q      <= 2'b01;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      q_q        <= 16'h0000;
      q_range_q  <= 2'b01;
      valid_q    <= 1'b0;
      cntover_q  <= 1'b0;
      cntlow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rng_q      <= rng_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      q_q        <= q_d;
      q_range_q  <= q_range_d;
      valid_q    <= valid_d;
      cntover_q  <= cntover_d;
      cntlow_q   <= cntlow_d;
    end
  end

  assign q       = q_q;
  assign q_range = q_range_q;
  assign valid   = valid_q;
  assign cntover = cntover_q;
  assign cntlow  = cntlow_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_bcd_counter.sv
// ----------------------------------------------------------------------------
// tb_gate_bcd_counter: directed vector table plus abort/mid-gate/closed-loop runs.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_gate_bcd_counter;

  localparam int GATE_1S = 40400;
  localparam int GW      = 16;

  logic        clk;
  logic        clear_n;
  logic        reset;
  logic [1:0]  std_f_sel;
  logic        fin;
  logic        cntover;
  logic        cntlow;
  logic [15:0] q;
  logic [1:0]  q_range;
  logic        valid;

  gate_bcd_counter #(.GATE_1S(GATE_1S), .GW(GW)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .reset     (reset),
    .std_f_sel (std_f_sel),
    .fin       (fin),
    .cntover   (cntover),
    .cntlow    (cntlow),
    .q         (q),
    .q_range   (q_range),
    .valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fin_half = 2;
  int ph = 0;

  // fin toggles every fin_half clocks, so its period is 2*fin_half clocks.
  initial begin
    fin = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      if (ph >= fin_half) begin
        fin = ~fin;
        ph  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (clear_n === 1'b1 && cntover === 1'b1 && cntlow === 1'b1) begin
      errors++;
      $display("FAIL flags_exclusive: cntover=1 cntlow=1 at %0t, required not both", $time);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int gate_len(input logic [1:0] s);
    if (s == 2'b11) return GATE_1S;
    if (s == 2'b00) return GATE_1S / 100;
    return GATE_1S / 10;
  endfunction

  task automatic wait_valid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0] sel;
    int         half;
    int         exp_q;
    int         tol;
    bit         over;
    bit         low;
  } vec_t;

  vec_t        vecs[5];
  bit          got;
  bit          seen;
  logic [15:0] q_prev;

  initial begin
    vecs[0] = '{2'b01, 2,  1010, 1, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 2,  101,  1, 1'b0, 1'b1};
    vecs[2] = '{2'b10, 2,  1010, 1, 1'b0, 1'b0};
    vecs[3] = '{2'b00, 20, 10,   1, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 2,  9999, 0, 1'b1, 1'b0};

    clear_n   = 1'b0;
    reset     = 1'b0;
    std_f_sel = 2'b01;

    // Clear held with fin toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("clr_q", int'(q), 0);
      chk("clr_q_range", int'(q_range), 1);
      chk("clr_flags_valid", int'({cntover, cntlow, valid}), 0);
    end
    clear_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      std_f_sel = vecs[i].sel;
      fin_half  = vecs[i].half;
      repeat (4) @(negedge clk);
      pulse_reset();
      wait_valid(gate_len(vecs[i].sel) + 50, got);
      chk($sformatf("v%0d_valid", i), int'(got), 1);
      if (got) begin
        chk_near($sformatf("v%0d_q", i), bcd2int(q), vecs[i].exp_q, vecs[i].tol);
        chk($sformatf("v%0d_q_range", i), int'(q_range), int'(vecs[i].sel));
        chk($sformatf("v%0d_cntover", i), int'(cntover), int'(vecs[i].over));
        chk($sformatf("v%0d_cntlow", i), int'(cntlow), int'(vecs[i].low));
        @(negedge clk);
        chk($sformatf("v%0d_pulse_width", i), int'({cntover, cntlow, valid}), 0);
      end
    end

    // Aborted gate: q keeps the previous (slow-fin) result until a full gate completes.
    std_f_sel = 2'b01;
    fin_half  = 20;
    repeat (4) @(negedge clk);
    pulse_reset();
    wait_valid(gate_len(2'b01) + 50, got);
    chk("abort_pre_valid", int'(got), 1);
    chk_near("abort_pre_q", bcd2int(q), 101, 1);
    q_prev   = q;
    fin_half = 2;
    seen     = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (valid || cntover || cntlow) seen = 1'b1;
    end
    pulse_reset();
    repeat (3000) begin
      @(negedge clk);
      if (valid || cntover || cntlow) seen = 1'b1;
    end
    chk("abort_no_report", int'(seen), 0);
    chk("abort_q_hold", int'(q), int'(q_prev));
    wait_valid(gate_len(2'b01) + 50, got);
    chk("abort_next_valid", int'(got), 1);
    chk_near("abort_next_q", bcd2int(q), 1010, 1);

    // Range change mid-gate applies only from the next ARM.
    repeat (10) @(negedge clk);
    std_f_sel = 2'b00;
    wait_valid(gate_len(2'b01) + 50, got);
    chk("midsel_valid", int'(got), 1);
    chk("midsel_q_range", int'(q_range), 1);
    chk_near("midsel_q", bcd2int(q), 1010, 1);
    wait_valid(gate_len(2'b00) + 50, got);
    chk("midsel_next_q_range", int'(q_range), 0);
    chk_near("midsel_next_q", bcd2int(q), 101, 1);

    // Closed loop: step range up on cntlow, new range taken in the ARM cycle.
    std_f_sel = 2'b00;
    fin_half  = 20;
    repeat (4) @(negedge clk);
    pulse_reset();
    wait_valid(gate_len(2'b00) + 50, got);
    chk("loop0_valid", int'(got), 1);
    chk("loop0_cntlow", int'(cntlow), 1);
    chk_near("loop0_q", bcd2int(q), 10, 1);
    if (cntlow) std_f_sel = 2'b01;
    wait_valid(gate_len(2'b01) + 50, got);
    chk("loop1_valid", int'(got), 1);
    chk("loop1_q_range", int'(q_range), 1);
    chk_near("loop1_q", bcd2int(q), 101, 1);
    chk("loop1_cntlow", int'(cntlow), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
